// File: rtl/mast_read_byte_ctrl_if.sv
// Request/handshake bundle between the I2C master top FSM, the SCL tick
// generator and the read byte sequencer. The slave side is the sequencer.
interface mast_read_byte_ctrl_if #(
  parameter int LEN_W = 8
);

  logic             master_rd_start;
  logic [LEN_W-1:0] master_rd_len;
  logic             master_abort;
  logic             master_scl_fall_tick;
  logic             master_scl_mid_tick;
  logic             master_rec_data_shift;
  logic             master_sda_ack_low;
  logic             master_rd_busy;
  logic             master_rd_byte_valid;
  logic             master_rd_last;
  logic             master_rd_done;

  modport slave (
    input  master_rd_start,
    input  master_rd_len,
    input  master_abort,
    input  master_scl_fall_tick,
    input  master_scl_mid_tick,
    output master_rec_data_shift,
    output master_sda_ack_low,
    output master_rd_busy,
    output master_rd_byte_valid,
    output master_rd_last,
    output master_rd_done
  );

  modport master (
    output master_rd_start,
    output master_rd_len,
    output master_abort,
    output master_scl_fall_tick,
    output master_scl_mid_tick,
    input  master_rec_data_shift,
    input  master_sda_ack_low,
    input  master_rd_busy,
    input  master_rd_byte_valid,
    input  master_rd_last,
    input  master_rd_done
  );

endinterface

// File: rtl/mast_read_byte_ctrl.sv
// Master-side I2C read sequencer. Walks the SIPO receive register through
// a burst of bytes: one shift per SCL data bit, eight bits per byte, then
// the master ACK (more bytes wanted) or NACK (final byte) on the ninth bit.
module mast_read_byte_ctrl #(
  parameter int LEN_W = 8
) (
  input logic                  master_scl_sixt,
  input logic                  master_rst,
  mast_read_byte_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    DATA,
    ACKW,
    ACK
  } state_t;

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [LEN_W-1:0] rem_cnt;
  logic             ack_low_q;
  logic             valid_q;
  logic             last_q;
  logic             done_q;
  logic             fall_tick;
  logic             mid_tick;

  // A fall tick wins over a coincident mid tick, so the mid tick is dropped.
  assign fall_tick = bus.master_scl_fall_tick;
  assign mid_tick  = bus.master_scl_mid_tick & ~bus.master_scl_fall_tick;

  // The shift enable is combinational so the SIPO captures on the edge that
  // closes the mid-tick cycle; reset suppresses it immediately.
  assign bus.master_rec_data_shift = (state == DATA) & mid_tick & ~master_rst;
  assign bus.master_rd_busy        = (state != IDLE);
  assign bus.master_sda_ack_low    = ack_low_q;
  assign bus.master_rd_byte_valid  = valid_q;
  assign bus.master_rd_last        = last_q;
  assign bus.master_rd_done        = done_q;

  // Burst sequencing FSM with registered pulse and ACK outputs; abort pulls
  // any active transfer back to IDLE without reporting a byte or completion.
  always_ff @(posedge master_scl_sixt) begin
    if (master_rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      rem_cnt   <= '0;
      ack_low_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      if ((state != IDLE) && bus.master_abort) begin
        state     <= IDLE;
        bit_cnt   <= 4'd0;
        rem_cnt   <= '0;
        ack_low_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.master_rd_start && (bus.master_rd_len != '0)) begin
              rem_cnt <= bus.master_rd_len;
              state   <= ARM;
            end
          end
          ARM: begin
            if (fall_tick) begin
              bit_cnt <= 4'd0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (mid_tick) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state   <= ACKW;
                valid_q <= 1'b1;
                last_q  <= (rem_cnt == LEN_W'(1));
              end
            end
          end
          ACKW: begin
            if (fall_tick) begin
              state     <= ACK;
              ack_low_q <= (rem_cnt > LEN_W'(1));
            end
          end
          ACK: begin
            if (fall_tick) begin
              ack_low_q <= 1'b0;
              rem_cnt   <= rem_cnt - LEN_W'(1);
              if (rem_cnt > LEN_W'(1)) begin
                bit_cnt <= 4'd0;
                state   <= DATA;
              end else begin
                state  <= IDLE;
                done_q <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mast_read_byte_ctrl.sv
// Testbench for mast_read_byte_ctrl: drives SCL ticks and serial data,
// keeps its own SIPO and a burst-level expectation of bytes, ACKs and pulses.
module tb_mast_read_byte_ctrl;

  localparam int LEN_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sda_bit = 1'b0;
  logic [7:0] sipo = 8'h00;

  int shift_seen = 0;
  int valid_seen = 0;
  int done_seen  = 0;
  int errors     = 0;
  int checks     = 0;

  logic obs_shift, obs_ack, obs_busy, obs_valid, obs_last, obs_done;
  logic [7:0] dir_data [4];

  mast_read_byte_ctrl_if #(.LEN_W(LEN_W)) bus ();

  mast_read_byte_ctrl #(.LEN_W(LEN_W)) dut (
    .master_scl_sixt(clk),
    .master_rst     (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Receive shift register fed by the serial bit the bench presents.
  always @(posedge clk) begin
    if (bus.master_rec_data_shift) sipo <= {sipo[6:0], sda_bit};
  end

  // Running tallies of shift, byte and completion pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.master_rec_data_shift) shift_seen <= shift_seen + 1;
      if (bus.master_rd_byte_valid)  valid_seen <= valid_seen + 1;
      if (bus.master_rd_done)        done_seen  <= done_seen + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given inputs; outputs are sampled mid-cycle.
  task automatic applyStimulus(input logic fall, input logic mid, input logic sbit,
                               input logic start, input logic [LEN_W-1:0] len,
                               input logic abort);
    bus.master_scl_fall_tick = fall;
    bus.master_scl_mid_tick  = mid;
    bus.master_rd_start      = start;
    bus.master_rd_len        = len;
    bus.master_abort         = abort;
    sda_bit                  = sbit;
    @(negedge clk);
    obs_shift = bus.master_rec_data_shift;
    obs_ack   = bus.master_sda_ack_low;
    obs_busy  = bus.master_rd_busy;
    obs_valid = bus.master_rd_byte_valid;
    obs_last  = bus.master_rd_last;
    obs_done  = bus.master_rd_done;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 2);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, '0, 0);
  endtask

  task automatic fall_tick();
    applyStimulus(1, 0, 0, 0, '0, 0);
  endtask

  // MSB-first bits, a fall tick delimiting each bit from the previous one.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i != 0) begin
        idle_gap();
        fall_tick();
      end
      idle_gap();
      applyStimulus(0, 1, b[7 - i], 0, '0, 0);
    end
  endtask

  task automatic check_byte(input logic [7:0] b, input logic last, input int idx);
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput($sformatf("valid_b%0d", idx), obs_valid, 1'b1);
    checkOutput($sformatf("last_b%0d", idx), obs_last, last);
    checkOutput($sformatf("sipo_b%0d", idx), sipo, b);
  endtask

  task automatic ack_phase(input logic exp_ack, input logic final_byte, input int idx);
    idle_gap();
    fall_tick();
    idle_gap();
    applyStimulus(0, 1, 1'($urandom), 0, '0, 0);
    checkOutput($sformatf("ack_b%0d", idx), obs_ack, exp_ack);
    checkOutput($sformatf("noshift_ack_b%0d", idx), obs_shift, 1'b0);
    idle_gap();
    fall_tick();
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput($sformatf("done_b%0d", idx), obs_done, final_byte);
    checkOutput($sformatf("busy_after_b%0d", idx), obs_busy, !final_byte);
    checkOutput($sformatf("ack_rel_b%0d", idx), obs_ack, 1'b0);
  endtask

  // Full burst: every byte lands in the SIPO, ACK on all but the last,
  // exactly 8*len shifts, len byte pulses and one completion pulse.
  task automatic run_burst(input int len, input logic use_dir, input logic poke_start);
    int s0, v0, d0;
    logic [7:0] b;
    s0 = shift_seen;
    v0 = valid_seen;
    d0 = done_seen;
    applyStimulus(0, 0, 0, 1, LEN_W'(len), 1'($urandom));
    if (poke_start) applyStimulus(0, 0, 0, 1, LEN_W'(5), 0);
    idle_gap();
    fall_tick();
    for (int i = 0; i < len; i++) begin
      b = use_dir ? dir_data[i] : 8'($urandom);
      send_bits(b, 8);
      check_byte(b, i == len - 1, i);
      if (poke_start && i == 0) applyStimulus(0, 0, 0, 1, LEN_W'(5), 0);
      ack_phase(i < len - 1, i == len - 1, i);
    end
    checkOutput("shift_count", shift_seen - s0, 8 * len);
    checkOutput("valid_count", valid_seen - v0, len);
    checkOutput("done_count", done_seen - d0, 1);
  endtask

  initial begin
    int s0, v0, d0;
    logic [7:0] b;

    // Reset overrides a concurrent start, abort and ticks.
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, 1, LEN_W'(3), 1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("rst_busy", obs_busy, 1'b0);
    checkOutput("rst_ack", obs_ack, 1'b0);
    checkOutput("rst_valid", obs_valid, 1'b0);
    checkOutput("rst_last", obs_last, 1'b0);
    checkOutput("rst_done", obs_done, 1'b0);
    checkOutput("rst_shift", obs_shift, 1'b0);

    // Single byte 0xA5, NACKed.
    dir_data[0] = 8'hA5;
    run_burst(1, 1, 0);

    // Three-byte burst.
    dir_data[0] = 8'h3C;
    dir_data[1] = 8'hFF;
    dir_data[2] = 8'h01;
    run_burst(3, 1, 0);

    // Zero-length request is ignored.
    s0 = shift_seen;
    v0 = valid_seen;
    d0 = done_seen;
    applyStimulus(0, 0, 0, 1, '0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, '0, 0);
      applyStimulus(0, 1, 1, 0, '0, 0);
      checkOutput("len0_busy", obs_busy, 1'b0);
    end
    checkOutput("len0_shifts", shift_seen - s0, 0);
    checkOutput("len0_valid", valid_seen - v0, 0);
    checkOutput("len0_done", done_seen - d0, 0);

    // Abort after the 4th bit of byte 2 in a 4-byte burst.
    s0 = shift_seen;
    v0 = valid_seen;
    d0 = done_seen;
    applyStimulus(0, 0, 0, 1, LEN_W'(4), 0);
    idle_gap();
    fall_tick();
    b = 8'($urandom);
    send_bits(b, 8);
    check_byte(b, 1'b0, 0);
    ack_phase(1'b1, 1'b0, 0);
    send_bits(8'($urandom), 4);
    applyStimulus(0, 0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("abort_busy", obs_busy, 1'b0);
    checkOutput("abort_ack", obs_ack, 1'b0);
    send_bits(8'hFF, 8);
    idle_gap();
    fall_tick();
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("abort_shifts", shift_seen - s0, 12);
    checkOutput("abort_valid", valid_seen - v0, 1);
    checkOutput("abort_done", done_seen - d0, 0);

    // Reset while the master is driving ACK low.
    applyStimulus(0, 0, 0, 1, LEN_W'(3), 0);
    idle_gap();
    fall_tick();
    b = 8'($urandom);
    send_bits(b, 8);
    check_byte(b, 1'b0, 0);
    fall_tick();
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("pre_rst_ack", obs_ack, 1'b1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, '0, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("midrst_busy", obs_busy, 1'b0);
    checkOutput("midrst_ack", obs_ack, 1'b0);
    checkOutput("midrst_valid", obs_valid, 1'b0);
    checkOutput("midrst_last", obs_last, 1'b0);
    checkOutput("midrst_done", obs_done, 1'b0);
    run_burst(2, 0, 0);

    // Start requests while busy must not disturb a 2-byte burst.
    run_burst(2, 0, 1);

    // Random bursts.
    for (int r = 0; r < 4; r++) run_burst($urandom_range(1, 4), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mast_read_byte_ctrl.md
Name: mast_read_byte_ctrl

Overview:
- Master-side read sequencer for I2C read transfers.
- Sequences the master SIPO receive register across N bytes:
  - raises its shift enable once per SCL data bit;
  - counts 8 bits per byte;
  - drives the master ACK/NACK bit after each byte;
  - flags each completed byte to the host side.
- Sits between the master top-level FSM (which issues read requests after the address phase) and the SIPO/SDA output stage.
- Runs on the oversampled SCL-domain clock.

Parameters:
LEN_W, 8, width of byte-count request (max burst 2^LEN_W-1 bytes)

Ports:
master_scl_sixt  input  1  block clock (same clock as SIPO register)
master_rst  input  1  reset; synchronous to master_scl_sixt, active-high
master_rd_start  input  1  one-cycle read request; accepted only in IDLE
master_rd_len  input  LEN_W  bytes to read; sampled with master_rd_start
master_abort  input  1  stop/arbitration-lost; forces IDLE
master_scl_fall_tick  input  1  one-cycle pulse at each SCL falling edge
master_scl_mid_tick  input  1  one-cycle pulse at midpoint of each SCL high phase
master_rec_data_shift  output  1  SIPO shift enable
master_sda_ack_low  output  1  1 = master pulls SDA low (ACK)
master_rd_busy  output  1  transfer in progress
master_rd_byte_valid  output  1  one-cycle pulse: SIPO holds a complete byte
master_rd_last  output  1  qualifies byte_valid: this is the final byte
master_rd_done  output  1  one-cycle pulse: burst complete

Behaviour:
- All state updates on posedge master_scl_sixt.
- Reset (any cycle, including mid-transfer):
  - state = IDLE; bit count = 0; remaining count = 0.
  - All outputs 0.
- States: IDLE, ARM, DATA, ACKW, ACK.
- IDLE:
  - master_rd_start=1 with master_rd_len!=0: latch len into remaining count, go ARM.
  - len==0: request ignored, stay IDLE, no pulses.
  - busy=0 only in IDLE.
- ARM:
  - Wait for master_scl_fall_tick (end of address ACK bit).
  - On tick: bit count = 0, go DATA.
- DATA:
  - master_rec_data_shift = (state==DATA) & master_scl_mid_tick. This is combinational, so the SIPO captures on the same edge that ends that cycle.
  - Each mid tick increments bit count.
  - On the 8th mid tick (count 7->8): go ACKW.
  - Fall ticks in DATA only delimit bits; no state change.
- master_rd_byte_valid:
  - Registered pulse, high exactly the cycle after the 8th shift edge (SIPO output already updated).
  - master_rd_last = 1 in that cycle iff remaining count == 1; else 0.
- ACKW:
  - Wait for fall tick (start of 9th bit).
  - On tick: go ACK. master_sda_ack_low registered to 1 if remaining > 1 (ACK), 0 if remaining == 1 (NACK = release).
- ACK:
  - master_sda_ack_low held constant.
  - On next fall tick: ack_low -> 0 and decrement remaining.
    - Remaining was > 1: go DATA, bit count = 0. This fall tick is the low phase of the next byte's bit 7.
    - Remaining was 1: go IDLE; master_rd_done pulses 1 cycle, in the first IDLE cycle.
- Mid ticks outside DATA are ignored; master_rec_data_shift is never asserted outside DATA.
- master_abort:
  - Any non-IDLE state: go IDLE next edge; ack_low = 0; no byte_valid, no done.
  - A byte_valid already registered for the current cycle still appears.
  - Ignored in IDLE.
- master_rd_start while busy: ignored; latched count unchanged.
- Simultaneous fall and mid tick (illegal from tick generator): fall tick takes priority, mid tick dropped.
- Abort and start in the same cycle in IDLE: start accepted.
- Reset beats abort and start.
- Remaining counter is LEN_W bits; it never underflows because it exits at 1.

Test Plan:
- Single byte:
  - Stimulus: start len=1; fall tick; 8 mid ticks with serial 1,0,1,0,0,1,0,1; fall; fall.
  - Required: exactly 8 shift pulses; SIPO=0xA5; byte_valid=1 and last=1 one cycle after the 8th shift; ack_low stays 0 (NACK); done pulses once; busy falls with done.
- Three-byte burst:
  - Stimulus: start len=3 with data 0x3C, 0xFF, 0x01.
  - Required: byte_valid three times with last=0,0,1; ack_low=1 during the 9th bit of bytes 1–2, 0 for byte 3; 24 shifts total; one done.
- len=0 start:
  - Required: busy stays 0; no shift, valid or done pulses.
- Abort after 4th mid tick of byte 2 (len=4):
  - Required: next cycle IDLE, busy=0, ack_low=0; no further shifts on later mid ticks; no done.
- Reset asserted during ACK with ack_low=1:
  - Required: next cycle all outputs 0.
  - A new start len=2 afterwards completes normally with 16 shifts.
- Start pulsed while busy with len=5 during a len=2 burst:
  - Required: ignored; exactly 2 byte_valid pulses and 1 done.
